// File: rtl/ex_muldiv_if.sv
// Handshake/data bundle between EX-stage control and the multi-cycle mul/div unit.
// Master drives the request side; slave (the unit) returns status and HI/LO results.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] hi_i;
    logic [XLEN-1:0] lo_i;
    logic            flush;
    logic            busy;
    logic            stallreq;
    logic            done;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic            div_by_zero;

    modport master (
        output start, op, src_a, src_b, hi_i, lo_i, flush,
        input  busy, stallreq, done, hi_o, lo_o, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b, hi_i, lo_i, flush,
        output busy, stallreq, done, hi_o, lo_o, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for EX with HI/LO result and pipeline stall request.
// Define EX_MULDIV_MACC_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise ops 1xx complete as a no-op.
module ex_muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN);
`ifdef EX_MULDIV_MACC_EN
    localparam logic [CW-1:0] MACC_LAST = CW'(MUL_LATENCY);
`endif

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      op_reg, op_next;
    logic [XLEN-1:0] a_reg, a_next, b_reg, b_next;
    logic [XLEN-1:0] acc_hi_reg, acc_hi_next, acc_lo_reg, acc_lo_next;
    logic [XLEN-1:0] rem_reg, rem_next, quo_reg, quo_next, dvs_reg, dvs_next;
    logic [XLEN-1:0] hi_reg, hi_next, lo_reg, lo_next;
    logic            dbz_reg, dbz_next;

    logic              idle, busy, is_signed, is_div_op;
    logic [2:0]        op_cur;
    logic [XLEN-1:0]   a_cur, b_cur, mag_a, mag_b;
    logic [2*XLEN-1:0] acc_cur, prod_mag, product, mul_result;
    logic              prod_neg, quo_neg, rem_neg;
    logic [XLEN-1:0]   quo_fix, rem_fix, step_rem, step_quo;
    logic [CW-1:0]     mul_last;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0]   sh;
        logic [XLEN-1:0] diff;
        sh   = {rem, quo[XLEN-1]};
        diff = sh[XLEN-1:0] - dvs;
        if (sh >= {1'b0, dvs})
            div_step = {diff, quo[XLEN-2:0], 1'b1};
        else
            div_step = {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    endfunction

    // In IDLE the operand path looks straight at the inputs so the start cycle can do real work.
    assign idle      = (state_reg == S_IDLE);
    assign busy      = (state_reg == S_MUL) || (state_reg == S_DIV);
    assign op_cur    = idle ? bus.op    : op_reg;
    assign a_cur     = idle ? bus.src_a : a_reg;
    assign b_cur     = idle ? bus.src_b : b_reg;
    assign acc_cur   = idle ? {bus.hi_i, bus.lo_i} : {acc_hi_reg, acc_lo_reg};
    assign is_signed = ~op_cur[0];
    assign is_div_op = (op_cur[2:1] == 2'b01);

    assign mag_a    = (is_signed && a_cur[XLEN-1]) ? -a_cur : a_cur;
    assign mag_b    = (is_signed && b_cur[XLEN-1]) ? -b_cur : b_cur;
    assign prod_mag = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign prod_neg = is_signed && (a_cur[XLEN-1] ^ b_cur[XLEN-1]);
    assign product  = prod_neg ? -prod_mag : prod_mag;

`ifdef EX_MULDIV_MACC_EN
    assign mul_result = !op_cur[2] ? product
                      : (op_cur[1] ? acc_cur - product : acc_cur + product);
    assign mul_last   = op_cur[2] ? MACC_LAST : MUL_LAST;
`else
    assign mul_result = product;
    assign mul_last   = MUL_LAST;
`endif

    assign {step_rem, step_quo} = idle ? div_step('0, mag_a, mag_b)
                                       : div_step(rem_reg, quo_reg, dvs_reg);

    assign quo_neg = is_signed && (a_cur[XLEN-1] ^ b_cur[XLEN-1]);
    assign rem_neg = is_signed && a_cur[XLEN-1];
    assign quo_fix = quo_neg ? -quo_reg : quo_reg;
    assign rem_fix = rem_neg ? -rem_reg : rem_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dvs_next    = dvs_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        dbz_next    = dbz_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    op_next     = bus.op;
                    a_next      = bus.src_a;
                    b_next      = bus.src_b;
                    acc_hi_next = bus.hi_i;
                    acc_lo_next = bus.lo_i;
                    cnt_next    = CNT_ONE;
                    if (is_div_op) begin
                        if (b_cur == '0) begin
                            state_next = S_DONE;
                            hi_next    = a_cur;
                            lo_next    = '1;
                            dbz_next   = 1'b1;
                        end else begin
                            // First quotient bit is resolved in the start cycle itself.
                            state_next = S_DIV;
                            rem_next   = step_rem;
                            quo_next   = step_quo;
                            dvs_next   = mag_b;
                        end
                    end
`ifndef EX_MULDIV_MACC_EN
                    else if (op_cur[2]) begin
                        state_next           = S_DONE;
                        {hi_next, lo_next}   = acc_cur;
                        dbz_next             = 1'b0;
                    end
`endif
                    else if (mul_last == '0) begin
                        state_next         = S_DONE;
                        {hi_next, lo_next} = mul_result;
                        dbz_next           = 1'b0;
                    end else begin
                        state_next = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (cnt_reg == mul_last) begin
                    state_next         = S_DONE;
                    {hi_next, lo_next} = mul_result;
                    dbz_next           = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_DIV: begin
                if (cnt_reg == DIV_LAST) begin
                    // Sign-fixup cycle: result is corrected on its way into HI/LO.
                    state_next = S_DONE;
                    hi_next    = rem_fix;
                    lo_next    = quo_fix;
                    dbz_next   = 1'b0;
                end else begin
                    rem_next = step_rem;
                    quo_next = step_quo;
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Flush beats everything, including a same-cycle start; HI/LO keep the last result.
        if (bus.flush) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            hi_next    = hi_reg;
            lo_next    = lo_reg;
            dbz_next   = dbz_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dbz_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dvs_reg    <= dvs_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            dbz_reg    <= dbz_next;
        end
    end

    assign bus.busy        = busy;
    assign bus.stallreq    = (idle && bus.start && !bus.flush) || busy;
    assign bus.done        = (state_reg == S_DONE);
    assign bus.hi_o        = hi_reg;
    assign bus.lo_o        = lo_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO/latency pushed at issue, popped at done.
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(XLEN)) bus ();

    ex_muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    // Reference model: sign-extended 64-bit arithmetic, language division for DIV.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo);
        exp_t        e;
        logic [63:0] ea, eb, p, acc;
        longint      da, db, q, r;
        e.dbz = 1'b0;
        ea    = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
        eb    = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
        p     = ea * eb;
        acc   = {hi, lo};
        case (op)
            3'b000, 3'b001: begin
                {e.hi, e.lo} = p;
                e.lat        = LAT;
            end
            3'b010, 3'b011: begin
                if (b == 32'h0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                    e.lat = 1;
                end else begin
                    da    = $signed(ea);
                    db    = $signed(eb);
                    q     = da / db;
                    r     = da % db;
                    e.hi  = r[31:0];
                    e.lo  = q[31:0];
                    e.lat = XLEN + 1;
                end
            end
            default: begin
`ifdef EX_MULDIV_MACC_EN
                {e.hi, e.lo} = op[1] ? acc - p : acc + p;
                e.lat        = LAT + 1;
`else
                {e.hi, e.lo} = acc;
                e.lat        = 1;
`endif
            end
        endcase
        return e;
    endfunction

    // Issues one op and waits (bounded) for done; lat=-1 on timeout. No comparisons here.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          output int lat, output logic [31:0] ohi, output logic [31:0] olo,
                          output logic odbz, output logic [63:0] stall_hist);
        stall_hist = '0;
        lat  = -1;
        ohi  = 'x;
        olo  = 'x;
        odbz = 1'bx;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        bus.hi_i = hi; bus.lo_i = lo;
        #1 stall_hist[0] = bus.stallreq;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        for (int i = 1; i < 100; i++) begin
            stall_hist[i] = bus.stallreq;
            if (bus.done) begin
                lat  = i;
                ohi  = bus.hi_o;
                olo  = bus.lo_o;
                odbz = bus.div_by_zero;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
        bus.src_a = '0; bus.src_b = '0; bus.hi_i = '0; bus.lo_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.stallreq, bus.done, bus.div_by_zero} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got busy/stall/done/dbz=%b%b%b%b want 0000",
                     bus.busy, bus.stallreq, bus.done, bus.div_by_zero);
        end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo got %h_%h want 0_0", bus.hi_o, bus.lo_o);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_mult();
        logic [2:0]  ops[5] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
        logic [31:0] as[5]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd6};
        logic [31:0] bs[5]  = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
        int lat; logic [31:0] ohi, olo; logic odbz; logic [63:0] sh; exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(model(ops[i], as[i], bs[i], 32'h0, 32'h0));
            run_op(ops[i], as[i], bs[i], 32'h0, 32'h0, lat, ohi, olo, odbz, sh);
            e = sb.pop_front();
            last_exp = e;
            $display("mul op=%b a=%h b=%h -> hi=%h lo=%h lat=%0d", ops[i], as[i], bs[i], ohi, olo, lat);
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL mul_lat[%0d] got %0d want %0d", i, lat, e.lat); end
            checks++;
            if ({ohi, olo} !== {e.hi, e.lo}) begin
                errors++; $display("FAIL mul_res[%0d] got %h_%h want %h_%h", i, ohi, olo, e.hi, e.lo);
            end
            if (i == 0) begin
                checks++;
                if (sh[3:0] !== 4'b0111) begin
                    errors++; $display("FAIL mul_stallreq got T..T+3=%b want 0111 (lsb=T)", sh[3:0]);
                end
            end
        end
    endtask

    task automatic test_div();
        logic [2:0] op; logic [31:0] a, b;
        int lat; logic [31:0] ohi, olo; logic odbz; logic [63:0] sh; exp_t e;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin op = 3'b011; a = 32'd100; b = 32'd7; end
                1: begin op = 3'b010; a = 32'hFFFF_FFF9; b = 32'd2; end
                2: begin op = 3'b010; a = 32'd7; b = 32'hFFFF_FFFE; end
                3: begin op = 3'b011; a = 32'hFFFF_FFFF; b = 32'd1; end
                default: begin
                    op = {2'b01, 1'($urandom_range(0, 1))};
                    a  = $urandom;
                    b  = $urandom >> $urandom_range(0, 28);
                    if (b == 32'h0) b = 32'd3;
                end
            endcase
            sb.push_back(model(op, a, b, 32'h0, 32'h0));
            run_op(op, a, b, 32'h0, 32'h0, lat, ohi, olo, odbz, sh);
            e = sb.pop_front();
            last_exp = e;
            $display("div op=%b a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d", op, a, b, ohi, olo, odbz, lat);
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL div_lat[%0d] got %0d want %0d", i, lat, e.lat); end
            checks++;
            if ({ohi, olo, odbz} !== {e.hi, e.lo, e.dbz}) begin
                errors++; $display("FAIL div_res[%0d] got %h_%h dbz=%b want %h_%h dbz=%b",
                                   i, ohi, olo, odbz, e.hi, e.lo, e.dbz);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops[4] = '{3'b010, 3'b011, 3'b010, 3'b010};
        logic [31:0] as[4]  = '{32'd5, 32'h0, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFF};
        int lat; logic [31:0] ohi, olo; logic odbz; logic [63:0] sh; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model(ops[i], as[i], bs[i], 32'h0, 32'h0));
            run_op(ops[i], as[i], bs[i], 32'h0, 32'h0, lat, ohi, olo, odbz, sh);
            e = sb.pop_front();
            last_exp = e;
            $display("divspecial op=%b a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d",
                     ops[i], as[i], bs[i], ohi, olo, odbz, lat);
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL divsp_lat[%0d] got %0d want %0d", i, lat, e.lat); end
            checks++;
            if ({ohi, olo, odbz} !== {e.hi, e.lo, e.dbz}) begin
                errors++; $display("FAIL divsp_res[%0d] got %h_%h dbz=%b want %h_%h dbz=%b",
                                   i, ohi, olo, odbz, e.hi, e.lo, e.dbz);
            end
        end
    endtask

    task automatic test_flush();
        int lat; int dones; logic [31:0] ohi, olo; logic odbz; logic [63:0] sh; exp_t e;
        // DIVU started at T, flushed at T+10.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b011; bus.src_a = 32'd100; bus.src_b = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (i == 10);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.stallreq, bus.done} !== 3'b000) begin
            errors++; $display("FAIL flush_idle got busy/stall/done=%b%b%b want 000", bus.busy, bus.stallreq, bus.done);
        end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== {last_exp.hi, last_exp.lo}) begin
            errors++; $display("FAIL flush_hold got %h_%h want %h_%h", bus.hi_o, bus.lo_o, last_exp.hi, last_exp.lo);
        end
        // New MULTU at T+12, then watch past where the flushed divide would have finished.
        sb.push_back(model(3'b001, 32'd6, 32'd7, 32'h0, 32'h0));
        run_op(3'b001, 32'd6, 32'd7, 32'h0, 32'h0, lat, ohi, olo, odbz, sh);
        e = sb.pop_front();
        last_exp = e;
        $display("post-flush multu 6*7 -> hi=%h lo=%h lat=%0d", ohi, olo, lat);
        checks++;
        if (lat !== e.lat || {ohi, olo} !== {e.hi, e.lo}) begin
            errors++; $display("FAIL flush_next got lat=%0d %h_%h want lat=%0d %h_%h", lat, ohi, olo, e.lat, e.hi, e.lo);
        end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL flush_nodone got %0d dones want 0", dones); end
        // flush and start together: start is dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b000; bus.src_a = 32'd3; bus.src_b = 32'd3;
        #1;
        checks++;
        if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL flush_start_stall got %b want 0", bus.stallreq); end
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL flush_start_drop got busy/done=%b%b want 00", bus.busy, bus.done);
        end
        $display("flush scenarios complete");
    endtask

    task automatic test_back_to_back();
        int lat; int dones; logic [31:0] ohi, olo; logic odbz; exp_t e;
        // start stays high with a different op while the divide runs, and again in the DONE cycle.
        sb.push_back(model(3'b011, 32'd100, 32'd7, 32'h0, 32'h0));
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b011; bus.src_a = 32'd100; bus.src_b = 32'd7;
        lat = -1; dones = 0; ohi = 'x; olo = 'x; odbz = 1'bx;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i <= 3) begin
                bus.start = 1'b1; bus.op = 3'b001; bus.src_a = 32'd6; bus.src_b = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = i; ohi = bus.hi_o; olo = bus.lo_o; odbz = bus.div_by_zero;
                    bus.start = 1'b1; bus.op = 3'b000; bus.src_a = 32'd2; bus.src_b = 32'd3;
                end
            end
        end
        e = sb.pop_front();
        last_exp = e;
        $display("held-start divu 100/7 -> hi=%h lo=%h lat=%0d dones=%0d", ohi, olo, lat, dones);
        checks++;
        if (lat !== e.lat || {ohi, olo, odbz} !== {e.hi, e.lo, e.dbz}) begin
            errors++; $display("FAIL b2b_first got lat=%0d %h_%h want lat=%0d %h_%h", lat, ohi, olo, e.lat, e.hi, e.lo);
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL b2b_ignored got %0d dones want 1", dones); end
    endtask

    task automatic test_macc();
        logic [2:0]  ops[4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as[4]  = '{32'd1, 32'd1, 32'hFFFF_FFFE, 32'd5};
        logic [31:0] bs[4]  = '{32'd1, 32'd1, 32'd3, 32'hFFFF_FFFD};
        logic [31:0] his[4] = '{32'h0, 32'h0, 32'h0, 32'h1234_5678};
        logic [31:0] los[4] = '{32'hFFFF_FFFF, 32'h0, 32'd10, 32'h9ABC_DEF0};
        int lat; logic [31:0] ohi, olo; logic odbz; logic [63:0] sh; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model(ops[i], as[i], bs[i], his[i], los[i]));
            run_op(ops[i], as[i], bs[i], his[i], los[i], lat, ohi, olo, odbz, sh);
            e = sb.pop_front();
            last_exp = e;
            $display("macc op=%b a=%h b=%h acc=%h_%h -> hi=%h lo=%h lat=%0d",
                     ops[i], as[i], bs[i], his[i], los[i], ohi, olo, lat);
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL macc_lat[%0d] got %0d want %0d", i, lat, e.lat); end
            checks++;
            if ({ohi, olo} !== {e.hi, e.lo}) begin
                errors++; $display("FAIL macc_res[%0d] got %h_%h want %h_%h", i, ohi, olo, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b011; bus.src_a = 32'd100; bus.src_b = 32'd7;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rst = (i == 5);
        end
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.stallreq, bus.done, bus.div_by_zero, bus.hi_o, bus.lo_o} !== 68'h0) begin
            errors++; $display("FAIL midreset_outs got busy/stall/done/dbz=%b%b%b%b hilo=%h_%h want all 0",
                               bus.busy, bus.stallreq, bus.done, bus.div_by_zero, bus.hi_o, bus.lo_o);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midreset_nodone got %0d dones want 0", dones); end
        $display("mid-operation reset complete");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_special();
        test_flush();
        test_back_to_back();
        test_macc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
